mor1kx_pic_sched: RTL and testbench

Interrupt scheduler between the PIC status register and the CPU exception unit. It picks one pending, unmasked, not-in-service interrupt line and presents it as a single vectored request with a request/acknowledge handshake. It tracks the in-service line until end-of-interrupt and issues a one-cycle clear pulse back toward the PIC status register. It also counts requests that were withdrawn before being acknowledged (spurious).

---
 rtl/mor1kx_pic_pkg.sv | 15 +
 rtl/mor1kx_pic_sched_sel.sv | 33 +++
 rtl/mor1kx_pic_sched.sv | 150 +++++++++++++++
 tb/tb_mor1kx_pic_sched.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mor1kx_pic_pkg.sv
// Shared constants for the mor1kx PIC interrupt scheduler: FSM state encoding
// and default widths.
package mor1kx_pic_pkg;

   localparam int unsigned PIC_NUM_IRQ_DEF = 32;
   localparam int unsigned PIC_ID_W_DEF    = 5;
   localparam int unsigned PIC_SPUR_W_DEF  = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } sched_state_t;

endpackage

// File: rtl/mor1kx_pic_sched_sel.sv
// Combinational find-first-set over the candidate vector, starting at a rotate
// offset and wrapping at NUM_IRQ-1 -> 0. A zero offset gives lowest-index-wins.
module mor1kx_pic_sched_sel
   import mor1kx_pic_pkg::*;
#(
   parameter int NUM_IRQ = PIC_NUM_IRQ_DEF,
   parameter int ID_W    = PIC_ID_W_DEF
) (
   input  logic [NUM_IRQ-1:0] vec_i,
   input  logic [ID_W-1:0]    offset_i,
   output logic               valid_o,
   output logic [ID_W-1:0]    idx_o
);

   int                 pos;
   logic [NUM_IRQ-1:0] shifted;

   // Scan from the farthest position back to the offset so the nearest hit wins.
   always_comb begin
      valid_o = 1'b0;
      idx_o   = {ID_W{1'b0}};
      pos     = 0;
      shifted = {NUM_IRQ{1'b0}};
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         pos     = ((int'(offset_i) + i) >= NUM_IRQ) ? (int'(offset_i) + i - NUM_IRQ)
                                                     : (int'(offset_i) + i);
         shifted = vec_i >> pos;
         idx_o   = shifted[0] ? ID_W'(pos) : idx_o;
         valid_o = valid_o | shifted[0];
      end
   end

endmodule

// File: rtl/mor1kx_pic_sched.sv
// Interrupt scheduler: PIC status -> single vectored request with ack/EOI handshake.
// Define MOR1KX_PIC_SCHED_RR_EN for round-robin selection (default: fixed priority).
module mor1kx_pic_sched
   import mor1kx_pic_pkg::*;
#(
   parameter int NUM_IRQ = PIC_NUM_IRQ_DEF,
   parameter int ID_W    = PIC_ID_W_DEF,
   parameter int SPUR_W  = PIC_SPUR_W_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_IRQ-1:0] picsr_i,
   input  logic               irq_ack_i,
   input  logic               irq_eoi_i,
   output logic               irq_req_o,
   output logic [ID_W-1:0]    irq_id_o,
   output logic [NUM_IRQ-1:0] picsr_clr_o,
   output logic [NUM_IRQ-1:0] isr_o,
   output logic [SPUR_W-1:0]  spur_cnt_o
);

   localparam logic [NUM_IRQ-1:0] LINE_ONE = {{(NUM_IRQ-1){1'b0}}, 1'b1};
   localparam logic [SPUR_W-1:0]  SPUR_MAX = {SPUR_W{1'b1}};
   localparam logic [SPUR_W-1:0]  SPUR_ONE = {{(SPUR_W-1){1'b0}}, 1'b1};

   sched_state_t       state_q, state_d;
   logic               req_q, req_d;
   logic [ID_W-1:0]    id_q, id_d;
   logic [NUM_IRQ-1:0] clr_q, clr_d;
   logic [NUM_IRQ-1:0] isr_q, isr_d;
   logic [SPUR_W-1:0]  spur_q, spur_d;

   logic [NUM_IRQ-1:0] cand;
   logic [NUM_IRQ-1:0] id_hot;
   logic               line_live;
   logic               sel_valid;
   logic [ID_W-1:0]    sel_idx;
   logic [ID_W-1:0]    sel_off;

   assign cand      = picsr_i & ~isr_q;
   assign id_hot    = LINE_ONE << id_q;
   assign line_live = |(picsr_i & id_hot);

`ifdef MOR1KX_PIC_SCHED_RR_EN
   localparam logic [ID_W-1:0] PTR_RST = ID_W'(NUM_IRQ - 1);
   localparam logic [ID_W-1:0] ID_ONE  = {{(ID_W-1){1'b0}}, 1'b1};

   logic [ID_W-1:0] ptr_q, ptr_d;

   // Pointer follows acknowledged grants only; search begins one past it.
   always_comb begin
      ptr_d   = (state_q == REQ && irq_ack_i) ? id_q : ptr_q;
      sel_off = (ptr_q == PTR_RST) ? {ID_W{1'b0}} : (ptr_q + ID_ONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= PTR_RST;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`else
   assign sel_off = {ID_W{1'b0}};
`endif

   mor1kx_pic_sched_sel #(
      .NUM_IRQ (NUM_IRQ),
      .ID_W    (ID_W)
   ) u_sel (
      .vec_i    (cand),
      .offset_i (sel_off),
      .valid_o  (sel_valid),
      .idx_o    (sel_idx)
   );

   // Next-state logic; the clear pulse defaults low so it lasts exactly one cycle.
   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      id_d    = id_q;
      clr_d   = {NUM_IRQ{1'b0}};
      isr_d   = isr_q;
      spur_d  = spur_q;
      case (state_q)
         IDLE: begin
            if (sel_valid) begin
               state_d = REQ;
               req_d   = 1'b1;
               id_d    = sel_idx;
            end else begin
               state_d = IDLE;
            end
         end
         REQ: begin
            if (irq_ack_i) begin
               state_d = SERVICE;
               req_d   = 1'b0;
               isr_d   = id_hot;
               clr_d   = id_hot;
            end else if (!line_live) begin
               state_d = IDLE;
               req_d   = 1'b0;
               spur_d  = (spur_q == SPUR_MAX) ? spur_q : (spur_q + SPUR_ONE);
            end else begin
               state_d = REQ;
            end
         end
         SERVICE: begin
            if (irq_eoi_i) begin
               state_d = IDLE;
               isr_d   = {NUM_IRQ{1'b0}};
            end else begin
               state_d = SERVICE;
            end
         end
         default: begin
            state_d = IDLE;
            req_d   = 1'b0;
            isr_d   = {NUM_IRQ{1'b0}};
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         req_q   <= 1'b0;
         id_q    <= {ID_W{1'b0}};
         clr_q   <= {NUM_IRQ{1'b0}};
         isr_q   <= {NUM_IRQ{1'b0}};
         spur_q  <= {SPUR_W{1'b0}};
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         id_q    <= id_d;
         clr_q   <= clr_d;
         isr_q   <= isr_d;
         spur_q  <= spur_d;
      end
   end

   assign irq_req_o   = req_q;
   assign irq_id_o    = id_q;
   assign picsr_clr_o = clr_q;
   assign isr_o       = isr_q;
   assign spur_cnt_o  = spur_q;

endmodule

// File: tb/tb_mor1kx_pic_sched.sv
// Self-checking bench for mor1kx_pic_sched: directed plan plus randomized traffic
// against a behavioural model (honours MOR1KX_PIC_SCHED_RR_EN).
module tb_mor1kx_pic_sched;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] picsr = 32'd0;
   logic        ack = 1'b0;
   logic        eoi = 1'b0;
   logic        irq_req_o;
   logic [4:0]  irq_id_o;
   logic [31:0] picsr_clr_o;
   logic [31:0] isr_o;
   logic [7:0]  spur_cnt_o;

   int checks = 0;
   int errors = 0;

   // Model: request flag, requested/last id, in-service line (-1 none), counter, pointer.
   bit          m_req;
   int          m_id;
   int          m_isr;
   int          m_spur;
   int          m_ptr;
   logic [31:0] m_clr;

   mor1kx_pic_sched #(.NUM_IRQ(32), .ID_W(5), .SPUR_W(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .picsr_i     (picsr),
      .irq_ack_i   (ack),
      .irq_eoi_i   (eoi),
      .irq_req_o   (irq_req_o),
      .irq_id_o    (irq_id_o),
      .picsr_clr_o (picsr_clr_o),
      .isr_o       (isr_o),
      .spur_cnt_o  (spur_cnt_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_req  = 1'b0;
      m_id   = 0;
      m_isr  = -1;
      m_spur = 0;
      m_ptr  = 31;
      m_clr  = 32'd0;
   endtask

   task automatic model_edge();
      logic [31:0] nclr;
      bit          found;
      int          c;
      nclr  = 32'd0;
      found = 1'b0;
      if (m_req) begin
         if (ack) begin
            m_isr = m_id;
            nclr  = 32'd1 << m_id;
            m_req = 1'b0;
            m_ptr = m_id;
         end else if (((picsr >> m_id) & 32'd1) == 32'd0) begin
            m_req  = 1'b0;
            m_spur = (m_spur < 255) ? m_spur + 1 : 255;
         end
      end else if (m_isr >= 0) begin
         if (eoi) m_isr = -1;
      end else if (picsr != 32'd0) begin
         for (int k = 1; k <= 32; k++) begin
`ifdef MOR1KX_PIC_SCHED_RR_EN
            c = (m_ptr + k) % 32;
`else
            c = k - 1;
`endif
            if (!found && ((picsr >> c) & 32'd1) != 32'd0) begin
               found = 1'b1;
               m_id  = c;
            end
         end
         m_req = 1'b1;
      end
      m_clr = nclr;
   endtask

   task automatic compare_all();
      chk("req", 32'(irq_req_o), 32'(m_req));
      chk("id", 32'(irq_id_o), m_id);
      chk("clr", picsr_clr_o, m_clr);
      chk("isr", isr_o, (m_isr < 0) ? 32'd0 : (32'd1 << m_isr));
      chk("spur", 32'(spur_cnt_o), m_spur);
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_req"}, 32'(irq_req_o), 32'd0);
      chk({tag, "_id"}, 32'(irq_id_o), 32'd0);
      chk({tag, "_clr"}, picsr_clr_o, 32'd0);
      chk({tag, "_isr"}, isr_o, 32'd0);
      chk({tag, "_spur"}, 32'(spur_cnt_o), 32'd0);
   endtask

   initial begin
      int rr_exp[4];
      int sel;
`ifdef MOR1KX_PIC_SCHED_RR_EN
      rr_exp = '{0, 3, 0, 3};
`else
      rr_exp = '{0, 0, 0, 0};
`endif
      // Power-on reset
      model_reset();
      #1;
      check_reset_values("rst");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Priority: 0x110 -> line 4 first, then line 8
      picsr = 32'h0000_0110;
      tick();
      chk("fp_req", 32'(irq_req_o), 32'd1);
      chk("fp_id4", 32'(irq_id_o), 32'd4);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      chk("fp_clr", picsr_clr_o, 32'h10);
      chk("fp_isr", isr_o, 32'h10);
      chk("fp_noreq", 32'(irq_req_o), 32'd0);
      picsr = 32'h0000_0100;
      tick();
      chk("fp_clr_off", picsr_clr_o, 32'd0);
      eoi = 1'b1;
      tick();
      eoi = 1'b0;
      chk("fp_eoi_isr", isr_o, 32'd0);
      chk("fp_idle_gap", 32'(irq_req_o), 32'd0);
      tick();
      chk("fp_id8", 32'(irq_id_o), 32'd8);
      ack = 1'b1;
      picsr = 32'd0;
      tick();
      ack = 1'b0;
      eoi = 1'b1;
      tick();
      eoi = 1'b0;

      // Grant sequence with 0x9 held
      picsr = 32'h0000_0009;
      for (int g = 0; g < 4; g++) begin
         for (int w = 0; w < 5 && !irq_req_o; w++) tick();
         chk("rr_req", 32'(irq_req_o), 32'd1);
         chk("rr_id", 32'(irq_id_o), rr_exp[g]);
         ack = 1'b1;
         tick();
         ack = 1'b0;
         eoi = 1'b1;
         tick();
         eoi = 1'b0;
      end
      picsr = 32'd0;
      tick();

      // Spurious withdrawal
      picsr = 32'h4;
      tick();
      tick();
      picsr = 32'd0;
      tick();
      chk("spur_req", 32'(irq_req_o), 32'd0);
      chk("spur_one", 32'(spur_cnt_o), 32'd1);

      // Ack wins over simultaneous withdrawal
      picsr = 32'h4;
      tick();
      picsr = 32'd0;
      ack = 1'b1;
      tick();
      ack = 1'b0;
      chk("sim_isr", isr_o, 32'h4);
      chk("sim_spur", 32'(spur_cnt_o), 32'd1);
      eoi = 1'b1;
      tick();
      eoi = 1'b0;

      // Saturation after 300 withdrawals in total
      for (int r = 0; r < 299; r++) begin
         picsr = 32'h4;
         tick();
         tick();
         picsr = 32'd0;
         tick();
      end
      chk("spur_sat", 32'(spur_cnt_o), 32'd255);

      // Id held while a lower line arrives
      picsr = 32'h20;
      tick();
      picsr = 32'h22;
      repeat (3) tick();
      chk("stable_id", 32'(irq_id_o), 32'd5);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      chk("stable_isr", isr_o, 32'h20);

      // Reset mid-service, then stray ack/EOI
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_reset_values("mid_rst");
      picsr = 32'd0;
      @(posedge clk);
      #1;
      compare_all();
      @(negedge clk);
      rst_n = 1'b1;
      ack = 1'b1;
      eoi = 1'b1;
      tick();
      tick();
      check_reset_values("post_rst");
      ack = 1'b0;
      eoi = 1'b0;

      // Randomized traffic against the model
      for (int n = 0; n < 1500; n++) begin
         sel = int'($urandom_range(0, 3));
         case (sel)
            0:       picsr = 32'd0;
            1:       picsr = 32'd1 << $urandom_range(0, 31);
            2:       picsr = $urandom;
            default: picsr = picsr;
         endcase
         ack = ($urandom_range(0, 3) == 0);
         eoi = ($urandom_range(0, 2) == 0);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
